mdl_accmode_mch: RTL and testbench
==================================

Name: mdl_accmode_mch

Overview:
- Multi-channel successor of the access-mode flag block in the bubble memory controller.
- Tracks bootloader/user mode flags per bubble channel (NUM_CH) and the shared address-latch-data source flag (BOOTLOADER_n/USER).
- Adds a sync-wait timeout watchdog and channel-select error detection.
- Sits between the command register/BDI enable logic and the address latch/page sequencer; all state advances on 2 MHz clock-enable cycles only.

Parameters:
- NUM_CH, 2, number of bubble channels (1..8).
- CH_W, 3, width of channel select; must satisfy 2^CH_W >= NUM_CH.
- TIMEOUT_CYC, 2048, enabled cycles allowed between ALD set and the synced flag before timeout (>= 1).

Ports:
- i_MCLK  in  1  master clock.
- i_SYS_RST_n  in  1  asynchronous active-low reset.
- i_CLK2M_PCEN_n  in  1  active-low clock enable; state updates only when 0.
- i_SYS_RUN_FLAG  in  1  low = system halted; clears user mode.
- i_CMDREG_RST_n  in  1  active-low command register reset strobe.
- i_BDI_EN_SET_n  in  1  active-low bubble data-in enable set strobe.
- i_SYNCED_FLAG_SET_n  in  1  active-low synced-flag set; clears ALD.
- i_CH_SEL  in  CH_W  target channel for a user-mode set.
- o_UMODE_SET_n  out  1  combinational: i_CMDREG_RST_n | i_BDI_EN_SET_n.
- o_BMODE_n  out  NUM_CH  per-channel bootloader mode flag (0 = bootloader).
- o_UMODE_n  out  NUM_CH  per-channel user mode flag (0 = user).
- o_ALD_nB_U  out  1  address latch data source (0 = bootloader, 1 = user).
- o_ACT_CH  out  CH_W  channel latched at the last accepted set.
- o_SYNC_TIMEOUT  out  1  sticky sync-wait timeout.
- o_SEL_ERR  out  1  sticky out-of-range channel select error.

Behaviour:
- Async reset, all registers:
  - o_BMODE_n = all 0, o_UMODE_n = all 1.
  - o_ALD_nB_U = 0, o_ACT_CH = 0.
  - o_SYNC_TIMEOUT = 0, o_SEL_ERR = 0, timeout counter = 0.
  - Reset deassertion takes effect on the next i_MCLK edge; nothing changes while i_CLK2M_PCEN_n = 1.
- SET event: an enabled cycle with o_UMODE_SET_n = 0. Latency is one enabled edge.
  - i_CH_SEL < NUM_CH (valid): o_BMODE_n[ch] <= 1 and o_UMODE_n[ch] <= 0. Other channels are unchanged. o_ACT_CH <= i_CH_SEL. o_SYNC_TIMEOUT <= 0. Counter <= 0.
  - i_CH_SEL >= NUM_CH: no flag, ACT_CH or counter change. o_SEL_ERR <= 1. ALD is still evaluated per the ALD rules below.
- RUN clear: on an enabled cycle with i_SYS_RUN_FLAG = 0, all o_UMODE_n <= 1.
  - o_BMODE_n is not affected; only reset or SET touches it.
  - If SET and RUN clear occur together, RUN clear wins for o_UMODE_n. BMODE_n/ACT_CH still update.
- ALD flag, evaluated each enabled cycle:
  - ald_set = (SET with valid ch) OR (i_SYS_RUN_FLAG = 0).
  - ald_clr = (i_SYNCED_FLAG_SET_n = 0).
  - Set has priority over clear when both are active.
- Sync watchdog FSM, 2 states:
  - IDLE: counter = 0. Go to WAIT when o_ALD_nB_U goes 1.
  - WAIT: counter increments by 1 per enabled cycle.
    - ald_clr without ald_set: go to IDLE and reset the counter.
    - Counter reaches TIMEOUT_CYC-1 and increments: o_SYNC_TIMEOUT <= 1, counter saturates, stay in WAIT.
    - A new ald_set restarts the counter at 0.
  - o_SYNC_TIMEOUT clears only on a valid SET or reset. A synced clear after timeout returns the FSM to IDLE but leaves the flag set.
- o_SEL_ERR clears only on reset.
- Counter width is clog2(TIMEOUT_CYC+1) bits, unsigned, saturating with no wrap.
- Reset mid-WAIT aborts immediately to IDLE with all outputs at reset values.

Test Plan:
- Reset and idle: NUM_CH=2; release reset, hold all strobes high for 10 enabled cycles -> BMODE_n=2'b00, UMODE_n=2'b11, ALD=0, TIMEOUT=0, SEL_ERR=0.
- Channel set: RUN=1; pulse BDI_EN_SET_n=0 and CMDREG_RST_n=0 for one enabled cycle with CH_SEL=1 -> next enabled edge BMODE_n=2'b10, UMODE_n=2'b01, ACT_CH=1, ALD=1. Then SYNCED_FLAG_SET_n=0 -> ALD=0.
- Priority: SET CH_SEL=0 with RUN=0 and SYNCED_FLAG_SET_n=0 on the same enabled cycle -> BMODE_n[0]=1, UMODE_n=2'b11, ALD=1.
- Timeout: TIMEOUT_CYC=16; SET ch 0, no synced -> TIMEOUT=1 after exactly 16 enabled cycles and stays 1 while CLK2M_PCEN_n toggles. A synced strobe leaves it 1; the next valid SET clears it.
- Select error: NUM_CH=3, CH_SEL=3, SET strobe -> SEL_ERR=1, all mode flags unchanged, ALD stays 0 if RUN=1.
- Async reset mid-WAIT: assert i_SYS_RST_n=0 between MCLK edges at counter=7 -> outputs return to reset values immediately without a clock edge.

Source files
------------

// File: rtl/mdl_accmode_mch.sv
// Per-channel bootloader/user access-mode flags, shared ALD source flag,
// sync-wait watchdog and channel-select error detection. Advances on 2 MHz enables only.
module mdl_accmode_mch #(
  parameter int NUM_CH      = 2,
  parameter int CH_W        = 3,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic              i_MCLK,
  input  logic              i_SYS_RST_n,
  input  logic              i_CLK2M_PCEN_n,
  input  logic              i_SYS_RUN_FLAG,
  input  logic              i_CMDREG_RST_n,
  input  logic              i_BDI_EN_SET_n,
  input  logic              i_SYNCED_FLAG_SET_n,
  input  logic [CH_W-1:0]   i_CH_SEL,
  output logic              o_UMODE_SET_n,
  output logic [NUM_CH-1:0] o_BMODE_n,
  output logic [NUM_CH-1:0] o_UMODE_n,
  output logic              o_ALD_nB_U,
  output logic [CH_W-1:0]   o_ACT_CH,
  output logic              o_SYNC_TIMEOUT,
  output logic              o_SEL_ERR
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CH_W:0]    CH_LIM   = (CH_W + 1)'(NUM_CH);

  typedef enum logic {ST_IDLE, ST_WAIT} wd_state_t;

  wd_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic              en;
  logic              set_ev;
  logic              sel_ok;
  logic              set_ok;
  logic              ald_set;
  logic              ald_clr;
  logic [NUM_CH-1:0] ch_hit;

  assign o_UMODE_SET_n = i_CMDREG_RST_n | i_BDI_EN_SET_n;
  assign en            = ~i_CLK2M_PCEN_n;
  assign set_ev        = ~o_UMODE_SET_n;
  assign sel_ok        = {1'b0, i_CH_SEL} < CH_LIM;
  assign set_ok        = set_ev & sel_ok;
  assign ald_set       = set_ok | ~i_SYS_RUN_FLAG;
  assign ald_clr       = ~i_SYNCED_FLAG_SET_n;

  always_comb begin
    ch_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit[c] = set_ok && (i_CH_SEL == CH_W'(c));
    end
  end

  // Mode flags, active channel, ALD source and select error
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      o_BMODE_n  <= '0;
      o_UMODE_n  <= '1;
      o_ALD_nB_U <= 1'b0;
      o_ACT_CH   <= '0;
      o_SEL_ERR  <= 1'b0;
    end else if (en) begin
      o_BMODE_n <= o_BMODE_n | ch_hit;
      // a halted system forces every channel out of user mode, even over a set
      if (!i_SYS_RUN_FLAG) o_UMODE_n <= '1;
      else                 o_UMODE_n <= o_UMODE_n & ~ch_hit;
      if (set_ok) o_ACT_CH <= i_CH_SEL;
      if (set_ev && !sel_ok) o_SEL_ERR <= 1'b1;
      if (ald_set)      o_ALD_nB_U <= 1'b1;
      else if (ald_clr) o_ALD_nB_U <= 1'b0;
    end
  end

  // Sync-wait watchdog
  always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
    if (!i_SYS_RST_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      o_SYNC_TIMEOUT <= 1'b0;
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (ald_set) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ald_set) begin
            cnt <= '0;
          end else if (ald_clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) o_SYNC_TIMEOUT <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
      if (set_ok) o_SYNC_TIMEOUT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdl_accmode_mch.sv
// Randomized bench for mdl_accmode_mch against a flag-level behavioural model.
module tb_mdl_accmode_mch;

  localparam int NCH = 3;
  localparam int CW  = 2;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pcen_n, run, cmd_n, bdi_n, syn_n;
  logic [CW-1:0] sel;
  logic          uset_n;
  logic [NCH-1:0] bm_n, um_n;
  logic          ald, tmo, serr;
  logic [CW-1:0] act;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit [NCH-1:0] m_bm, m_um;
  bit           m_ald, m_to, m_err, m_wait;
  int           m_act, m_cnt;

  mdl_accmode_mch #(.NUM_CH(NCH), .CH_W(CW), .TIMEOUT_CYC(TO)) dut (
    .i_MCLK             (clk),
    .i_SYS_RST_n        (rst_n),
    .i_CLK2M_PCEN_n     (pcen_n),
    .i_SYS_RUN_FLAG     (run),
    .i_CMDREG_RST_n     (cmd_n),
    .i_BDI_EN_SET_n     (bdi_n),
    .i_SYNCED_FLAG_SET_n(syn_n),
    .i_CH_SEL           (sel),
    .o_UMODE_SET_n      (uset_n),
    .o_BMODE_n          (bm_n),
    .o_UMODE_n          (um_n),
    .o_ALD_nB_U         (ald),
    .o_ACT_CH           (act),
    .o_SYNC_TIMEOUT     (tmo),
    .o_SEL_ERR          (serr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bm = '0; m_um = '1; m_ald = 0; m_to = 0; m_err = 0;
    m_wait = 0; m_act = 0; m_cnt = 0;
  endtask

  // one enabled-cycle worth of the block's rules, written at flag level
  task automatic model_edge();
    bit set, valid, aset, aclr;
    int s;
    if (pcen_n) return;
    s     = int'(sel);
    set   = !(cmd_n || bdi_n);
    valid = s < NCH;
    aset  = (set && valid) || !run;
    aclr  = !syn_n;
    if (set && valid) begin
      m_bm[s] = 1'b1;
      m_um[s] = 1'b0;
      m_act   = s;
      m_to    = 0;
    end
    if (set && !valid) m_err = 1;
    if (!run) m_um = '1;
    if (!m_wait) begin
      if (aset) begin m_wait = 1; m_cnt = 0; end
    end else if (aset) begin
      m_cnt = 0;
    end else if (aclr) begin
      m_wait = 0; m_cnt = 0;
    end else if (m_cnt < TO) begin
      m_cnt++;
      if (m_cnt == TO) m_to = 1;
    end
    if (aset) m_ald = 1;
    else if (aclr) m_ald = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bmode"}, 32'(bm_n), 32'(m_bm));
    chk({tag, ".umode"}, 32'(um_n), 32'(m_um));
    chk({tag, ".ald"},   32'(ald),  32'(m_ald));
    chk({tag, ".act"},   32'(act),  32'(m_act));
    chk({tag, ".tmo"},   32'(tmo),  32'(m_to));
    chk({tag, ".serr"},  32'(serr), 32'(m_err));
  endtask

  // drive just after a rising edge, predict, advance one edge, compare
  task automatic step(input bit p, input bit r, input bit c, input bit b,
                      input bit y, input int s, input string tag);
    pcen_n = p; run = r; cmd_n = c; bdi_n = b; syn_n = y; sel = CW'(s);
    #1;
    chk({tag, ".uset"}, 32'(uset_n), 32'(c | b));
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 1, 1, 1, 1, 0, tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_bm"},  32'(bm_n), 32'(0));
    chk({tag, ".rst_um"},  32'(um_n), 32'(3'b111));
    chk({tag, ".rst_ald"}, 32'(ald),  32'(0));
    chk({tag, ".rst_act"}, 32'(act),  32'(0));
    chk({tag, ".rst_tmo"}, 32'(tmo),  32'(0));
    chk({tag, ".rst_err"}, 32'(serr), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pcen_n = 1'b0; run = 1'b1; cmd_n = 1'b1; bdi_n = 1'b1;
    syn_n = 1'b1; sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    do_reset("por");

    for (int i = 0; i < 10; i++) idle("idle");
    chk("idle_bm",  32'(bm_n), 32'(0));
    chk("idle_um",  32'(um_n), 32'(3'b111));
    chk("idle_ald", 32'(ald),  32'(0));

    step(0, 1, 0, 0, 1, 1, "set1");
    chk("set1_bm",  32'(bm_n), 32'(3'b010));
    chk("set1_um",  32'(um_n), 32'(3'b101));
    chk("set1_act", 32'(act),  32'(1));
    chk("set1_ald", 32'(ald),  32'(1));
    step(0, 1, 1, 1, 0, 0, "sync1");
    chk("sync1_ald", 32'(ald), 32'(0));

    step(0, 0, 0, 0, 0, 0, "prio");
    chk("prio_bm0", 32'(bm_n[0]), 32'(1));
    chk("prio_um",  32'(um_n),    32'(3'b111));
    chk("prio_ald", 32'(ald),     32'(1));

    step(0, 1, 0, 0, 1, 0, "to_set");
    for (int i = 1; i <= TO; i++) begin
      step(1, 1, 1, 1, 1, 0, "to_gap");
      idle("to_run");
      if (i == TO - 1) chk("to_early", 32'(tmo), 32'(0));
    end
    chk("to_hit", 32'(tmo), 32'(1));
    for (int i = 0; i < 6; i++) step(i[0], 1, 1, 1, 1, 0, "to_hold");
    chk("to_hold", 32'(tmo), 32'(1));
    step(0, 1, 1, 1, 0, 0, "to_sync");
    chk("to_sync_tmo", 32'(tmo), 32'(1));
    chk("to_sync_ald", 32'(ald), 32'(0));
    step(0, 1, 0, 0, 1, 2, "to_clr");
    chk("to_clr", 32'(tmo), 32'(0));

    do_reset("serr");
    step(0, 1, 0, 0, 1, 3, "selerr");
    chk("selerr_err", 32'(serr), 32'(1));
    chk("selerr_bm",  32'(bm_n), 32'(0));
    chk("selerr_um",  32'(um_n), 32'(3'b111));
    chk("selerr_ald", 32'(ald),  32'(0));

    step(0, 1, 0, 0, 1, 0, "mid_set");
    for (int i = 0; i < 7; i++) idle("mid_wait");
    @(negedge clk);
    do_reset("midwait");

    for (int i = 0; i < 400; i++) begin
      bit s_set;
      s_set = ($urandom % 8) == 0;
      step(($urandom % 4) == 0, ($urandom % 20) != 0,
           s_set ? 1'b0 : 1'($urandom % 2), s_set ? 1'b0 : 1'b1,
           ($urandom % 10) != 0, int'($urandom % 4), "rnd");
    end
    for (int i = 0; i < 300; i++) begin
      bit s_set;
      s_set = ($urandom % 40) == 0;
      step(($urandom % 3) == 0, ($urandom % 60) != 0,
           s_set ? 1'b0 : 1'b1, s_set ? 1'b0 : 1'($urandom % 2),
           ($urandom % 40) != 0, int'($urandom % 4), "rndq");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
